vga_pattern_gen: RTL and testbench

Parametrised VGA timing and test-pattern generator, the successor to rtl_smpte. It derives a pixel-clock enable from the system clock, runs horizontal and vertical position counters, and drives registered sync, data-enable and RGB outputs. Four patterns are available: SMPTE bars, solid colour, checkerboard and grey ramp. Mode changes take effect only at frame boundaries, so every frame is glitch-free.

---
 rtl/vga_pattern_gen.sv | 250 +++++++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// VGA timing + test-pattern generator (SMPTE bars, solid, checker, ramp).
// Ports: clk; rst (sync, active-low); mode_i/color_i pattern select;
// red_px/green_px/blue_px, h_out, v_out, de_out registered video;
// h_poz/v_poz position counters; frame_start one-clk pulse at (0,0).
module vga_pattern_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_VIZ    = 640,
  parameter int H_FP     = 16,
  parameter int H_PULSE  = 96,
  parameter int H_BP     = 48,
  parameter int V_VIZ    = 480,
  parameter int V_FP     = 10,
  parameter int V_PULSE  = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int R_W      = 3,
  parameter int G_W      = 3,
  parameter int B_W      = 2,
  parameter int CNT_W    = 10,
  parameter int CHK_LOG2 = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode_i,
  input  logic [R_W+G_W+B_W-1:0] color_i,
  output logic [R_W-1:0]         red_px,
  output logic [G_W-1:0]         green_px,
  output logic [B_W-1:0]         blue_px,
  output logic                   h_out,
  output logic                   v_out,
  output logic                   de_out,
  output logic [CNT_W-1:0]       h_poz,
  output logic [CNT_W-1:0]       v_poz,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_VIZ + H_FP + H_PULSE + H_BP;
  localparam int V_TOTAL = V_VIZ + V_FP + V_PULSE + V_BP;
  localparam int C_W     = R_W + G_W + B_W;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_V    = CNT_W'(H_VIZ);
  localparam logic [CNT_W-1:0] V_V    = CNT_W'(V_VIZ);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_VIZ + H_FP);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_VIZ + H_FP + H_PULSE);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_VIZ + V_FP);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_VIZ + V_FP + V_PULSE);
  localparam logic [CNT_W-1:0] V_LOW  = CNT_W'(V_VIZ * 3 / 4);
  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);

  typedef enum logic [1:0] {
    M_SMPTE = 2'd0,
    M_SOLID = 2'd1,
    M_CHECK = 2'd2,
    M_RAMP  = 2'd3
  } mode_t;

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  mode_t            r_mode;
  logic [C_W-1:0]   r_color;
  logic [R_W-1:0]   r_red;
  logic [G_W-1:0]   r_grn;
  logic [B_W-1:0]   r_blu;
  logic             r_hs;
  logic             r_vs;
  logic             r_de;
  logic             r_fs;

  logic             w_ce;
  logic             w_h_end;
  logic             w_v_end;
  logic             w_de;
  logic             w_low;
  logic             w_chk;
  logic             w_hs_act;
  logic             w_vs_act;
  logic [2:0]       w_bar;
  logic [2:0]       w_step;
  logic [2:0]       w_flag;
  logic [R_W-1:0]   w_cr;
  logic [G_W-1:0]   w_cg;
  logic [B_W-1:0]   w_cb;
  logic [R_W-1:0]   w_r_ramp;
  logic [G_W-1:0]   w_g_ramp;
  logic [B_W-1:0]   w_b_ramp;
  logic [R_W-1:0]   w_r;
  logic [G_W-1:0]   w_g;
  logic [B_W-1:0]   w_b;

  // Thresholds fold to constants; no runtime division.
  function automatic logic [2:0] bar_idx(input logic [CNT_W-1:0] h);
    logic [2:0] b;
    b = '0;
    for (int k = 1; k <= 6; k++)
      if (h >= CNT_W'(k * H_VIZ / 7)) b = b + 3'd1;
    return b;
  endfunction

  function automatic logic [2:0] step_idx(input logic [CNT_W-1:0] h);
    logic [2:0] s;
    s = '0;
    for (int k = 1; k <= 7; k++)
      if (h >= CNT_W'(k * H_VIZ / 8)) s = s + 3'd1;
    return s;
  endfunction

  assign w_ce    = (r_div == DIV_LAST);
  assign w_h_end = (r_h == H_LAST);
  assign w_v_end = (r_v == V_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div   <= '0;
      r_h     <= '0;
      r_v     <= '0;
      r_mode  <= M_SMPTE;
      r_color <= '0;
    end else begin
      r_div <= w_ce ? '0 : r_div + DIV_W'(1);
      if (w_ce) begin
        r_h <= w_h_end ? '0 : r_h + CNT_W'(1);
        if (w_h_end)
          r_v <= w_v_end ? '0 : r_v + CNT_W'(1);
        // Latch on the last pixel so the new mode starts at (0,0).
        if (w_h_end && w_v_end) begin
          r_mode  <= mode_t'(mode_i);
          r_color <= color_i;
        end
      end
    end
  end

  assign w_cr     = r_color[C_W-1 -: R_W];
  assign w_cg     = r_color[G_W+B_W-1 -: G_W];
  assign w_cb     = r_color[B_W-1:0];
  assign w_bar    = bar_idx(r_h);
  assign w_step   = step_idx(r_h);
  assign w_de     = (r_h < H_V) && (r_v < V_V);
  assign w_low    = (r_v >= V_LOW);
  assign w_chk    = r_h[CHK_LOG2] ^ r_v[CHK_LOG2];
  assign w_hs_act = (r_h >= H_SS) && (r_h < H_SE);
  assign w_vs_act = (r_v >= V_SS) && (r_v < V_SE);

  // Ramp step left-aligned, repeated for channels wider than 3 bits.
  for (genvar i = 0; i < R_W; i++) begin : g_rr
    assign w_r_ramp[R_W-1-i] = w_step[2-(i%3)];
  end
  for (genvar i = 0; i < G_W; i++) begin : g_gr
    assign w_g_ramp[G_W-1-i] = w_step[2-(i%3)];
  end
  for (genvar i = 0; i < B_W; i++) begin : g_br
    assign w_b_ramp[B_W-1-i] = w_step[2-(i%3)];
  end

  // SMPTE full-scale flags {R,G,B} per bar.
  always_comb begin
    w_flag = 3'b000;
    if (w_low) begin
      case (w_bar)
        3'd0:    w_flag = 3'b001;
        3'd2:    w_flag = 3'b101;
        3'd4:    w_flag = 3'b011;
        3'd6:    w_flag = 3'b111;
        default: w_flag = 3'b000;
      endcase
    end else begin
      case (w_bar)
        3'd0:    w_flag = 3'b111;
        3'd1:    w_flag = 3'b110;
        3'd2:    w_flag = 3'b011;
        3'd3:    w_flag = 3'b010;
        3'd4:    w_flag = 3'b101;
        3'd5:    w_flag = 3'b100;
        default: w_flag = 3'b001;
      endcase
    end
  end

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (w_de) begin
      unique case (r_mode)
        M_SMPTE: begin
          w_r = {R_W{w_flag[2]}};
          w_g = {G_W{w_flag[1]}};
          w_b = {B_W{w_flag[0]}};
        end
        M_SOLID: begin
          w_r = w_cr;
          w_g = w_cg;
          w_b = w_cb;
        end
        M_CHECK: begin
          if (w_chk) begin
            w_r = w_cr;
            w_g = w_cg;
            w_b = w_cb;
          end
        end
        M_RAMP: begin
          w_r = w_r_ramp;
          w_g = w_g_ramp;
          w_b = w_b_ramp;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_red <= '0;
      r_grn <= '0;
      r_blu <= '0;
      r_hs  <= ~HS_ON;
      r_vs  <= ~VS_ON;
      r_de  <= 1'b0;
      r_fs  <= 1'b0;
    end else begin
      r_fs <= w_ce && (r_h == '0) && (r_v == '0);
      if (w_ce) begin
        r_red <= w_r;
        r_grn <= w_g;
        r_blu <= w_b;
        r_hs  <= w_hs_act ? HS_ON : ~HS_ON;
        r_vs  <= w_vs_act ? VS_ON : ~VS_ON;
        r_de  <= w_de;
      end
    end
  end

  assign red_px      = r_red;
  assign green_px    = r_grn;
  assign blue_px     = r_blu;
  assign h_out       = r_hs;
  assign v_out       = r_vs;
  assign de_out      = r_de;
  assign h_poz       = r_h;
  assign v_poz       = r_v;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: a small-timing instance (A, CLK_DIV=2)
// and a 640-wide instance (B, CLK_DIV=1), table vectors plus sequences.
module tb_vga_pattern_gen;

  localparam int LIMIT = 20000;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [1:0] mode_a, mode_b;
  logic [7:0] color_a, color_b;

  logic [2:0] red_a;
  logic [3:0] grn_a;
  logic [0:0] blu_a;
  logic       hs_a, vs_a, de_a, fs_a;
  logic [4:0] hp_a, vp_a;

  logic [2:0] red_b;
  logic [2:0] grn_b;
  logic [1:0] blu_b;
  logic       hs_b, vs_b, de_b, fs_b;
  logic [9:0] hp_b, vp_b;

  vga_pattern_gen #(
    .CLK_DIV(2), .H_VIZ(8), .H_FP(2), .H_PULSE(2), .H_BP(4),
    .V_VIZ(6), .V_FP(1), .V_PULSE(1), .V_BP(2),
    .R_W(3), .G_W(4), .B_W(1), .CNT_W(5), .CHK_LOG2(1)
  ) u_a (
    .clk(clk), .rst(rst_a), .mode_i(mode_a), .color_i(color_a),
    .red_px(red_a), .green_px(grn_a), .blue_px(blu_a),
    .h_out(hs_a), .v_out(vs_a), .de_out(de_a),
    .h_poz(hp_a), .v_poz(vp_a), .frame_start(fs_a)
  );

  vga_pattern_gen #(
    .CLK_DIV(1), .H_VIZ(640), .H_FP(16), .H_PULSE(32), .H_BP(32),
    .V_VIZ(8), .V_FP(1), .V_PULSE(1), .V_BP(1)
  ) u_b (
    .clk(clk), .rst(rst_b), .mode_i(mode_b), .color_i(color_b),
    .red_px(red_b), .green_px(grn_b), .blue_px(blu_b),
    .h_out(hs_b), .v_out(vs_b), .de_out(de_b),
    .h_poz(hp_b), .v_poz(vp_b), .frame_start(fs_b)
  );

  typedef struct packed {
    bit s;
    int m;
    int c;
    int h;
    int v;
    int r;
    int g;
    int b;
    int de;
  } vec_t;

  vec_t tbl[$];
  int   errs;
  int   checks;
  int   cur_m[2];
  int   cur_c[2];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input bit s, input int m, input int c,
                     input int h, input int v, input int r,
                     input int g, input int b, input int de);
    vec_t t;
    t.s = s; t.m = m; t.c = c; t.h = h; t.v = v;
    t.r = r; t.g = g; t.b = b; t.de = de;
    tbl.push_back(t);
  endtask

  task automatic get_pos(input bit s, output int h, output int v);
    h = s ? int'(hp_b) : int'(hp_a);
    v = s ? int'(vp_b) : int'(vp_a);
  endtask

  task automatic get_pix(input bit s, output int r, output int g,
                         output int b, output int de);
    r  = s ? int'(red_b) : int'(red_a);
    g  = s ? int'(grn_b) : int'(grn_a);
    b  = s ? int'(blu_b) : int'(blu_a);
    de = s ? int'(de_b)  : int'(de_a);
  endtask

  task automatic wait_pos(input bit s, input int h, input int v,
                          output bit ok);
    int ch, cv, n;
    n = 0;
    get_pos(s, ch, cv);
    while (!(ch == h && cv == v) && n < LIMIT) begin
      @(negedge clk);
      n++;
      get_pos(s, ch, cv);
    end
    ok = (ch == h && cv == v);
  endtask

  // Returns once the outputs for pixel (h,v) are registered.
  task automatic wait_pix(input bit s, input int h, input int v,
                          output bit ok);
    int ch, cv, n;
    wait_pos(s, h, v, ok);
    if (ok) begin
      n = 0;
      get_pos(s, ch, cv);
      while (ch == h && cv == v && n < LIMIT) begin
        @(negedge clk);
        n++;
        get_pos(s, ch, cv);
      end
      ok = !(ch == h && cv == v);
    end
  endtask

  task automatic wait_fs(input bit s, output int n, output bit ok);
    n = 0;
    ok = 0;
    while (!ok && n < LIMIT) begin
      @(negedge clk);
      n++;
      ok = s ? fs_b : fs_a;
    end
  endtask

  // Never change inputs between the latch edge and the (0,0) edge.
  task automatic set_mode(input bit s, input int m, input int c);
    int ch, cv, n;
    bit ok;
    n = 0;
    get_pos(s, ch, cv);
    while (ch == 0 && cv == 0 && n < 8) begin
      @(negedge clk);
      n++;
      get_pos(s, ch, cv);
    end
    if (s) begin
      mode_b = 2'(m); color_b = 8'(c);
    end else begin
      mode_a = 2'(m); color_a = 8'(c);
    end
    wait_fs(s, n, ok);
    chk("mode_fs_seen", int'(ok), 1);
    cur_m[s] = m;
    cur_c[s] = c;
  endtask

  task automatic chk_pix(input string nm, input bit s, input int r,
                         input int g, input int b, input int de);
    int ar, ag, ab, ad;
    get_pix(s, ar, ag, ab, ad);
    chk({nm, "_r"}, ar, r);
    chk({nm, "_g"}, ag, g);
    chk({nm, "_b"}, ab, b);
    chk({nm, "_de"}, ad, de);
  endtask

  initial begin
    int  n;
    bit  ok;
    int  hl, vl, den, fsn, rh, rv, rd, mh, mv, md, last;
    errs = 0;
    checks = 0;
    cur_m[0] = 0; cur_m[1] = 0;
    cur_c[0] = 0; cur_c[1] = 0;
    rst_a = 0; rst_b = 0;
    mode_a = 0; mode_b = 0;
    color_a = 0; color_b = 0;

    // A (3/4/1): white 7/15/1. B (3/3/2): white 7/7/3.
    add(0, 0, 0,   0, 0,  7, 15, 1, 1);
    add(0, 0, 0,   3, 0,  0, 15, 0, 1);
    add(0, 0, 0,   1, 4,  0,  0, 0, 1);
    add(0, 0, 0,   2, 5,  7,  0, 1, 1);
    add(0, 0, 0,   7, 5,  7, 15, 1, 1);
    add(0, 0, 0,   8, 5,  0,  0, 0, 0);
    add(0, 2, 255, 0, 1,  0,  0, 0, 1);
    add(0, 2, 255, 2, 1,  7, 15, 1, 1);
    add(0, 2, 255, 2, 2,  0,  0, 0, 1);
    add(0, 2, 255, 0, 3,  7, 15, 1, 1);
    add(0, 2, 255, 8, 3,  0,  0, 0, 0);
    add(0, 3, 255, 3, 1,  3,  6, 0, 1);
    add(0, 3, 255, 5, 1,  5, 11, 1, 1);
    add(0, 3, 255, 6, 1,  6, 13, 1, 1);
    add(0, 3, 255, 7, 5,  7, 15, 1, 1);
    add(1, 0, 0,     0, 0,  7, 7, 3, 1);
    add(1, 0, 0,   100, 0,  7, 7, 0, 1);
    add(1, 0, 0,   639, 0,  0, 0, 3, 1);
    add(1, 0, 0,   640, 0,  0, 0, 0, 0);
    add(1, 0, 0,   700, 3,  0, 0, 0, 0);
    add(1, 0, 0,   400, 6,  0, 7, 3, 1);
    add(1, 0, 0,     0, 7,  0, 0, 3, 1);
    add(1, 0, 0,   100, 7,  0, 0, 0, 1);
    add(1, 0, 0,   560, 7,  7, 7, 3, 1);
    add(1, 1, 224,   5, 2,  7, 0, 0, 1);
    add(1, 1, 224, 639, 7,  7, 0, 0, 1);
    add(1, 1, 224, 650, 7,  0, 0, 0, 0);
    add(1, 2, 255,   0, 1,  0, 0, 0, 1);
    add(1, 2, 255,  32, 1,  7, 7, 3, 1);
    add(1, 2, 255,  64, 1,  0, 0, 0, 1);
    add(1, 2, 255,  96, 4,  7, 7, 3, 1);
    add(1, 3, 0,     0, 1,  0, 0, 0, 1);
    add(1, 3, 0,    80, 1,  1, 1, 0, 1);
    add(1, 3, 0,   250, 1,  3, 3, 1, 1);
    add(1, 3, 0,   559, 1,  6, 6, 3, 1);
    add(1, 3, 0,   639, 1,  7, 7, 3, 1);

    // Reset hold and release.
    repeat (5) @(negedge clk);
    chk_pix("rst_a", 0, 0, 0, 0, 0);
    chk_pix("rst_b", 1, 0, 0, 0, 0);
    chk("rst_a_fs", int'(fs_a), 0);
    chk("rst_a_hs", int'(hs_a), 1);
    chk("rst_a_vs", int'(vs_a), 1);
    chk("rst_a_h", int'(hp_a), 0);
    chk("rst_a_v", int'(vp_a), 0);
    chk("rst_b_fs", int'(fs_b), 0);
    chk("rst_b_hs", int'(hs_b), 1);
    chk("rst_b_vs", int'(vs_b), 1);
    chk("rst_b_h", int'(hp_b), 0);
    rst_a = 1; rst_b = 1;
    @(negedge clk);
    chk("rel1_fs_a", int'(fs_a), 0);
    chk("rel1_fs_b", int'(fs_b), 1);
    @(negedge clk);
    chk("rel2_fs_a", int'(fs_a), 1);
    chk("rel2_fs_b", int'(fs_b), 0);
    chk("lag_h_a", int'(hp_a), 1);
    chk("lag_v_a", int'(vp_a), 0);
    chk("rel2_h_b", int'(hp_b), 2);

    // Two full frames of A timing (320 clk each).
    hl = 0; vl = 0; den = 0; fsn = 0;
    rh = 0; rv = 0; rd = 0; mh = 0; mv = 0; md = 0; last = 0;
    for (int i = 1; i <= 640; i++) begin
      @(negedge clk);
      if (!hs_a) begin hl++; rh++; if (rh > mh) mh = rh; end
      else rh = 0;
      if (!vs_a) begin vl++; rv++; if (rv > mv) mv = rv; end
      else rv = 0;
      if (de_a) begin den++; rd++; if (rd > md) md = rd; end
      else rd = 0;
      if (fs_a) begin
        fsn++;
        chk("fs_period", i - last, 320);
        last = i;
      end
    end
    chk("hs_low_clks", hl, 80);
    chk("vs_low_clks", vl, 64);
    chk("de_clks", den, 192);
    chk("fs_count", fsn, 2);
    chk("hs_width", mh, 4);
    chk("vs_width", mv, 32);
    chk("de_width", md, 16);

    foreach (tbl[i]) begin
      if (tbl[i].m != cur_m[tbl[i].s] || tbl[i].c != cur_c[tbl[i].s])
        set_mode(tbl[i].s, tbl[i].m, tbl[i].c);
      wait_pix(tbl[i].s, tbl[i].h, tbl[i].v, ok);
      chk($sformatf("v%0d_reach", i), int'(ok), 1);
      chk_pix($sformatf("v%0d", i), tbl[i].s,
              tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].de);
    end

    // Mid-frame mode change waits for the frame boundary.
    set_mode(0, 0, 0);
    wait_pos(0, 0, 2, ok);
    chk("mc_reach", int'(ok), 1);
    mode_a = 2'd1;
    color_a = 8'hE0;
    wait_pix(0, 1, 3, ok);
    chk_pix("mc_old_top", 0, 7, 15, 0, 1);
    wait_pix(0, 0, 5, ok);
    chk_pix("mc_old_bot", 0, 0, 0, 1, 1);
    wait_fs(0, n, ok);
    chk("mc_fs", int'(ok), 1);
    chk_pix("mc_new00", 0, 7, 0, 0, 1);
    wait_pix(0, 3, 1, ok);
    chk_pix("mc_new31", 0, 7, 0, 0, 1);
    wait_pix(0, 9, 1, ok);
    chk_pix("mc_blank", 0, 0, 0, 0, 0);

    // One-clock reset mid-frame.
    mode_a = 2'd3;
    wait_pos(0, 5, 3, ok);
    chk("mr_reach", int'(ok), 1);
    rst_a = 0;
    @(negedge clk);
    chk("mr_h", int'(hp_a), 0);
    chk("mr_v", int'(vp_a), 0);
    chk("mr_hs", int'(hs_a), 1);
    chk("mr_fs", int'(fs_a), 0);
    chk_pix("mr_pix", 0, 0, 0, 0, 0);
    rst_a = 1;
    wait_fs(0, n, ok);
    chk("mr_first_fs", n, 2);
    chk_pix("mr_smpte00", 0, 7, 15, 1, 1);
    wait_fs(0, n, ok);
    chk("mr_frame_len", n, 320);
    chk_pix("mr_ramp00", 0, 0, 0, 0, 1);
    wait_pix(0, 5, 0, ok);
    chk_pix("mr_ramp50", 0, 5, 11, 1, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
